// File: rtl/gcbp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcbp_pkg
//  Description : Shared types and constants for the GCBP search scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package gcbp_pkg;

    localparam int C_SUBIMAGE_LINES = 64;
    localparam int C_NUM_SUBIMAGES  = 16;
    localparam int C_BRAM_ADDR_BITS = 9;
    localparam int C_FRAME_LOC_BITS = 2;

    localparam int C_LINE_BITS = $clog2(C_SUBIMAGE_LINES);
    localparam int C_SUB_BITS  = $clog2(C_NUM_SUBIMAGES);

    localparam logic [C_LINE_BITS-1:0] C_LAST_LINE = C_LINE_BITS'(C_SUBIMAGE_LINES - 1);
    localparam logic [C_SUB_BITS-1:0]  C_LAST_SUB  = C_SUB_BITS'(C_NUM_SUBIMAGES - 1);

    // Schedule phases: idle, current-frame lines, previous-frame lines, end pulse
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CURR = 2'd1,
        RD_PREV = 2'd2,
        DONE    = 2'd3
    } gcbp_state_e;

endpackage
`default_nettype wire

// File: rtl/gcbp_search_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : gcbp_search_sched_if
//  Description : BRAM read port and matcher line stream of the scheduler.
//                master = scheduler side, slave = BRAM/matcher side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gcbp_search_sched_if;
    import gcbp_pkg::*;

    logic                        i_match_ready;
    logic [C_BRAM_ADDR_BITS-1:0] o_bram_rd_addr;
    logic [C_NUM_SUBIMAGES-1:0]  o_bram_rd_en;
    logic                        o_line_valid;
    logic                        o_line_is_prev;
    logic [C_SUB_BITS-1:0]       o_subimage_idx;
    logic [C_LINE_BITS-1:0]      o_line_idx;

    modport master (
        input  i_match_ready,
        output o_bram_rd_addr, o_bram_rd_en,
        output o_line_valid, o_line_is_prev, o_subimage_idx, o_line_idx
    );

    modport slave (
        output i_match_ready,
        input  o_bram_rd_addr, o_bram_rd_en,
        input  o_line_valid, o_line_is_prev, o_subimage_idx, o_line_idx
    );

endinterface
`default_nettype wire

// File: rtl/gcbp_sched_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : gcbp_sched_addr_gen
//  Description : Forms the BRAM line address from frame location and line
//                number, and decodes the subimage into a one-hot enable.
//                Both outputs are zero when no read is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcbp_sched_addr_gen
    import gcbp_pkg::*;
(
    input  wire logic                        i_issue,
    input  wire logic [C_FRAME_LOC_BITS-1:0] i_loc,
    input  wire logic [C_SUB_BITS-1:0]       i_sub,
    input  wire logic [C_LINE_BITS-1:0]      i_line,
    output logic      [C_BRAM_ADDR_BITS-1:0] o_addr,
    output logic      [C_NUM_SUBIMAGES-1:0]  o_rd_en
);

    // Address is {0, location, line}; idle cycles drive zero so the bus is quiet
    always_comb begin
        o_addr = '0;
        if (i_issue) begin
            o_addr = {1'b0, i_loc, i_line};
        end
    end

    // One enable per subimage BRAM, only during an issue cycle
    for (genvar g = 0; g < C_NUM_SUBIMAGES; g++) begin : g_rd_en_dec
        localparam logic [C_SUB_BITS-1:0] C_IDX = C_SUB_BITS'(g);
        assign o_rd_en[g] = i_issue && (i_sub == C_IDX);
    end

endmodule
`default_nettype wire

// File: rtl/gcbp_search_sched.sv
`default_nettype none
// ============================================================================
//  Module      : gcbp_search_sched
//  Description : Walks all 16 subimages of the current and previous frame,
//                64 current lines then 64 previous lines per subimage, and
//                streams BRAM reads to the matcher with ready-based stalls.
//                Optional build macro GCBP_SCHED_STATS_EN adds
//                o_sched_cycles, the length of the last completed schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcbp_search_sched
    import gcbp_pkg::*;
(
    input  wire logic                        i_clk,
    input  wire logic                        i_resetn,
    input  wire logic                        i_frame_done,
    input  wire logic [C_FRAME_LOC_BITS-1:0] i_curr_frame_loc,
    input  wire logic [C_FRAME_LOC_BITS-1:0] i_prev_frame_loc,
    gcbp_search_sched_if.master              bus,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_overrun
`ifdef GCBP_SCHED_STATS_EN
    ,
    output logic [15:0]                      o_sched_cycles
`endif
);

    gcbp_state_e                 state_q, state_d;
    logic [C_SUB_BITS-1:0]       sub_q, sub_d;
    logic [C_LINE_BITS-1:0]      line_q, line_d;
    logic [C_FRAME_LOC_BITS-1:0] curr_loc_q, curr_loc_d;
    logic [C_FRAME_LOC_BITS-1:0] prev_loc_q, prev_loc_d;
    logic                        overrun_q, overrun_d;
    logic                        vld_q, vld_d;
    logic                        is_prev_q, is_prev_d;
    logic [C_SUB_BITS-1:0]       sub_idx_q, sub_idx_d;
    logic [C_LINE_BITS-1:0]      line_idx_q, line_idx_d;

    logic                        w_reading;
    logic                        w_issue;
    logic [C_FRAME_LOC_BITS-1:0] w_loc;

    assign w_reading = (state_q == RD_CURR) || (state_q == RD_PREV);
    assign w_issue   = w_reading && bus.i_match_ready;
    assign w_loc     = (state_q == RD_PREV) ? prev_loc_q : curr_loc_q;

    gcbp_sched_addr_gen u_addr_gen (
        .i_issue (w_issue),
        .i_loc   (w_loc),
        .i_sub   (sub_q),
        .i_line  (line_q),
        .o_addr  (bus.o_bram_rd_addr),
        .o_rd_en (bus.o_bram_rd_en)
    );

    // Next-state, counter stepping, location latch and line-tag pipeline
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        line_d     = line_q;
        curr_loc_d = curr_loc_q;
        prev_loc_d = prev_loc_q;
        // A new frame during any non-idle state (DONE included) is dropped
        overrun_d  = overrun_q | (i_frame_done && (state_q != IDLE));
        // BRAM data lands one cycle after the read, so the tags trail by one
        vld_d      = w_issue;
        is_prev_d  = w_issue && (state_q == RD_PREV);
        sub_idx_d  = w_issue ? sub_q  : '0;
        line_idx_d = w_issue ? line_q : '0;

        case (state_q)
            IDLE: begin
                if (i_frame_done) begin
                    state_d    = RD_CURR;
                    curr_loc_d = i_curr_frame_loc;
                    prev_loc_d = i_prev_frame_loc;
                    sub_d      = '0;
                    line_d     = '0;
                end
            end
            RD_CURR: begin
                if (w_issue) begin
                    if (line_q == C_LAST_LINE) begin
                        state_d = RD_PREV;
                        line_d  = '0;
                    end else begin
                        line_d  = line_q + 1'b1;
                    end
                end
            end
            RD_PREV: begin
                if (w_issue) begin
                    if (line_q != C_LAST_LINE) begin
                        line_d = line_q + 1'b1;
                    end else if (sub_q == C_LAST_SUB) begin
                        state_d = DONE;
                        sub_d   = '0;
                        line_d  = '0;
                    end else begin
                        state_d = RD_CURR;
                        sub_d   = sub_q + 1'b1;
                        line_d  = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q    <= IDLE;
            sub_q      <= '0;
            line_q     <= '0;
            curr_loc_q <= '0;
            prev_loc_q <= '0;
            overrun_q  <= 1'b0;
            vld_q      <= 1'b0;
            is_prev_q  <= 1'b0;
            sub_idx_q  <= '0;
            line_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            line_q     <= line_d;
            curr_loc_q <= curr_loc_d;
            prev_loc_q <= prev_loc_d;
            overrun_q  <= overrun_d;
            vld_q      <= vld_d;
            is_prev_q  <= is_prev_d;
            sub_idx_q  <= sub_idx_d;
            line_idx_q <= line_idx_d;
        end
    end

    assign bus.o_line_valid   = vld_q;
    assign bus.o_line_is_prev = is_prev_q;
    assign bus.o_subimage_idx = sub_idx_q;
    assign bus.o_line_idx     = line_idx_q;

    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_overrun = overrun_q;

`ifdef GCBP_SCHED_STATS_EN
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] sched_cycles_q, sched_cycles_d;

    // Cycle count since the accepted frame_done; value in DONE is the length
    always_comb begin
        cyc_d          = cyc_q;
        sched_cycles_d = sched_cycles_q;
        if ((state_q == IDLE) && i_frame_done) begin
            cyc_d = 16'd1;
        end else if ((state_q != IDLE) && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
        if (state_q == DONE) begin
            sched_cycles_d = cyc_q;
        end
    end

    // Statistics registers
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            cyc_q          <= '0;
            sched_cycles_q <= '0;
        end else begin
            cyc_q          <= cyc_d;
            sched_cycles_q <= sched_cycles_d;
        end
    end

    assign o_sched_cycles = sched_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcbp_search_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcbp_search_sched
//  Description : Self-checking bench for gcbp_search_sched: scenario table,
//                reset-abort sequence and randomized run against a schedule
//                model. Build with GCBP_SCHED_STATS_EN to cover o_sched_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcbp_search_sched;

    logic       clk = 1'b0;
    logic       resetn;
    logic       fd;
    logic [1:0] cl, pl;
    logic       ready;
    logic       busy, done, ov;
`ifdef GCBP_SCHED_STATS_EN
    logic [15:0] sc;
`endif

    always #5 clk = ~clk;

    gcbp_search_sched_if bus ();
    assign bus.i_match_ready = ready;

    gcbp_search_sched dut (
        .i_clk            (clk),
        .i_resetn         (resetn),
        .i_frame_done     (fd),
        .i_curr_frame_loc (cl),
        .i_prev_frame_loc (pl),
        .bus              (bus),
        .o_busy           (busy),
        .o_done           (done),
        .o_overrun        (ov)
`ifdef GCBP_SCHED_STATS_EN
        ,
        .o_sched_cycles   (sc)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        fd     = 1'b0;
        ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_ovr"},   int'(ov), 0);
        check({tag, "_rd_en"}, int'(bus.o_bram_rd_en), 0);
        check({tag, "_addr"},  int'(bus.o_bram_rd_addr), 0);
        check({tag, "_line"},  int'({bus.o_line_valid, bus.o_line_is_prev,
                                     bus.o_subimage_idx, bus.o_line_idx}), 0);
    endtask

    typedef struct {
        int cl, pl;
        int stall_at, stall_len;   // stall before issue index stall_at
        int extra_fd;              // cycle of an extra frame_done (0 = none)
        int reset_before;
        int e_first_addr, e_first_en, e_addr64, e_done;
        int e_ssub, e_sline;       // tags of first line after the stall
        int e_ov;
    } vec_t;

    // Runs one schedule from an idle DUT and checks its observable timeline
    task automatic run_sched(input string tag, input vec_t v);
        int cyc = 0, iss = 0, val = 0, stalled = 0;
        int first_addr = -1, first_en = -1, a64 = -1, done_cyc = -1;
        int ssub = -1, sline = -1, addr_err = 0, stall_err = 0;
        int d_vld = -1, d_prev = -1, d_line = -1, d_sub = -1;
        int loc, e_addr, e_en;
        if (v.reset_before != 0) begin
            do_reset();
            @(negedge clk);
            check({tag, "_ovr_after_reset"}, int'(ov), 0);
            @(posedge clk); #1;
        end
        cl = 2'(v.cl); pl = 2'(v.pl); fd = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        fd = 1'b0;
        cl = 2'(v.cl ^ 3); pl = 2'(v.pl ^ 3);
        cyc = 1;
        while (done_cyc < 0 && cyc < 6000) begin
            ready = 1'b1;
            if (v.stall_len > 0 && iss == v.stall_at && stalled < v.stall_len) begin
                ready = 1'b0;
                stalled++;
            end
            fd = (v.extra_fd != 0 && cyc == v.extra_fd);
            @(negedge clk);
            if (bus.o_bram_rd_en != '0) begin
                if (!ready) stall_err++;
                loc    = ((iss / 64) % 2 != 0) ? v.pl : v.cl;
                e_addr = loc * 64 + iss % 64;
                e_en   = 1 << (iss / 128);
                if (int'(bus.o_bram_rd_addr) != e_addr || int'(bus.o_bram_rd_en) != e_en)
                    addr_err++;
                if (iss == 0) begin
                    first_addr = int'(bus.o_bram_rd_addr);
                    first_en   = int'(bus.o_bram_rd_en);
                end
                if (iss == 64) a64 = int'(bus.o_bram_rd_addr);
                iss++;
            end
            if (bus.o_line_valid) begin
                val++;
                if (val == v.stall_at + 1) begin
                    ssub  = int'(bus.o_subimage_idx);
                    sline = int'(bus.o_line_idx);
                end
            end
            if (done) begin
                done_cyc = cyc;
                d_vld  = int'(bus.o_line_valid);
                d_prev = int'(bus.o_line_is_prev);
                d_line = int'(bus.o_line_idx);
                d_sub  = int'(bus.o_subimage_idx);
            end
            @(posedge clk); #1;
            fd = 1'b0;
            cyc++;
        end
        check({tag, "_first_addr"}, first_addr, v.e_first_addr);
        check({tag, "_first_en"},   first_en,   v.e_first_en);
        check({tag, "_addr_line64"}, a64,       v.e_addr64);
        check({tag, "_done_cycle"}, done_cyc,   v.e_done);
        check({tag, "_issues"},     iss,        2048);
        check({tag, "_valid_lines"}, val,       2048);
        check({tag, "_addr_seq_err"}, addr_err, 0);
        check({tag, "_stall_issue"}, stall_err, 0);
        if (v.stall_len > 0) begin
            check({tag, "_post_stall_sub"},  ssub,  v.e_ssub);
            check({tag, "_post_stall_line"}, sline, v.e_sline);
        end
        check({tag, "_done_valid"}, d_vld,  1);
        check({tag, "_done_prev"},  d_prev, 1);
        check({tag, "_done_line"},  d_line, 63);
        check({tag, "_done_sub"},   d_sub,  15);
        ready = 1'b1;
        @(negedge clk);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_done_after"}, int'(done), 0);
        check({tag, "_overrun"},    int'(ov),   v.e_ov);
`ifdef GCBP_SCHED_STATS_EN
        check({tag, "_sched_cycles"}, int'(sc), v.e_done);
`endif
        @(posedge clk); #1;
    endtask

    vec_t tbl[6];
    vec_t fresh;

    int m_ph, m_p, m_cl, m_pl, m_ov, m_vld, m_vprev, m_vsub, m_vline;
    int r_iss, r_addr, r_en, r_ok, r_prints;
    int n_done_abort;

    initial begin
        //            cl pl  st_at len xfd rst  addr0 en0  a64  done  ssub sl ov
        tbl[0] = '{1, 2, 0,    0,  0,   0, 'h040, 1, 'h080, 2049, 0,  0,  0};
        tbl[1] = '{3, 0, 670,  10, 0,   0, 'h0C0, 1, 'h000, 2059, 5,  30, 0};
        tbl[2] = '{2, 2, 100,  7,  0,   0, 'h080, 1, 'h080, 2056, 0,  36, 0};
        tbl[3] = '{0, 3, 2047, 3,  0,   0, 'h000, 1, 'h0C0, 2052, 15, 63, 0};
        tbl[4] = '{1, 2, 0,    0,  500, 0, 'h040, 1, 'h080, 2049, 0,  0,  1};
        tbl[5] = '{3, 1, 0,    0,  2049, 1,'h0C0, 1, 'h040, 2049, 0,  0,  1};

        resetn = 1'b0; fd = 1'b0; ready = 1'b0; cl = '0; pl = '0;
        do_reset();
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_sched($sformatf("row%0d", i), tbl[i]);
        end

        // Reset in the middle of a schedule: abort, no done, overrun cleared
        do_reset();
        cl = 2'd2; pl = 2'd1; fd = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        fd = 1'b0;
        n_done_abort = 0;
        for (int c = 1; c < 1000; c++) begin
            fd = (c == 200);
            @(negedge clk);
            if (done) n_done_abort++;
            @(posedge clk); #1;
        end
        fd = 1'b0;
        check("abort_ovr_set", int'(ov), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        if (done) n_done_abort++;
        check_all_zero("abort");
        check("abort_no_done", n_done_abort, 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        fresh = '{1, 2, 0, 0, 0, 0, 'h040, 1, 'h080, 2049, 0, 0, 0};
        run_sched("after_abort", fresh);

        // Randomized run against the schedule model
        do_reset();
        m_ph = 0; m_p = 0; m_cl = 0; m_pl = 0; m_ov = 0;
        m_vld = 0; m_vprev = 0; m_vsub = 0; m_vline = 0;
        r_prints = 0;
        for (int i = 0; i < 8000; i++) begin
            ready  = ($urandom_range(3) != 0);
            fd     = (m_ph == 0) ? ($urandom_range(7) == 0) : ($urandom_range(599) == 0);
            cl     = 2'($urandom);
            pl     = 2'($urandom);
            resetn = ($urandom_range(3999) != 0);
            @(negedge clk);
            r_iss  = (m_ph == 1 && ready) ? 1 : 0;
            r_addr = r_iss ? ((((m_p / 64) % 2 != 0) ? m_pl : m_cl) * 64 + m_p % 64) : 0;
            r_en   = r_iss ? (1 << (m_p / 128)) : 0;
            r_ok   = (int'(bus.o_bram_rd_addr) == r_addr) && (int'(bus.o_bram_rd_en) == r_en)
                  && (int'(bus.o_line_valid) == m_vld)
                  && (int'(busy) == ((m_ph != 0) ? 1 : 0))
                  && (int'(done) == ((m_ph == 2) ? 1 : 0))
                  && (int'(ov) == m_ov)
                  && (m_vld == 0 || (int'(bus.o_line_is_prev) == m_vprev
                                     && int'(bus.o_subimage_idx) == m_vsub
                                     && int'(bus.o_line_idx) == m_vline));
            n_vec++;
            if (!r_ok) begin
                n_bad++;
                if (r_prints < 10) begin
                    r_prints++;
                    $display("FAIL rand_cycle%0d: got addr=%0h en=%0h vld=%0d busy=%0d done=%0d ov=%0d expected addr=%0h en=%0h vld=%0d busy=%0d done=%0d ov=%0d",
                             i, bus.o_bram_rd_addr, bus.o_bram_rd_en, bus.o_line_valid,
                             busy, done, ov, r_addr, r_en, m_vld, (m_ph != 0), (m_ph == 2), m_ov);
                end
            end
            @(posedge clk);
            if (!resetn) begin
                m_ph = 0; m_p = 0; m_cl = 0; m_pl = 0; m_ov = 0;
                m_vld = 0; m_vprev = 0; m_vsub = 0; m_vline = 0;
            end else begin
                m_vld   = r_iss;
                m_vprev = r_iss ? (m_p / 64) % 2 : 0;
                m_vsub  = r_iss ? m_p / 128 : 0;
                m_vline = r_iss ? m_p % 64 : 0;
                if (m_ph == 0) begin
                    if (fd) begin
                        m_ph = 1; m_p = 0; m_cl = int'(cl); m_pl = int'(pl);
                    end
                end else begin
                    if (fd) m_ov = 1;
                    if (m_ph == 1) begin
                        if (r_iss != 0) begin
                            if (m_p == 2047) m_ph = 2;
                            else m_p++;
                        end
                    end else begin
                        m_ph = 0;
                    end
                end
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcbp_search_sched.md
GCBP_SEARCH_SCHED -- requirements
Module: gcbp_search_sched

Interface
REQ-001 SHALL have: i_clk  in  1  clock; all logic on rising edge.
REQ-002 SHALL have: i_resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: i_frame_done  in  1  one-cycle pulse; all 16 subimages of the new frame are written to the BRAM array.
REQ-004 SHALL have: i_curr_frame_loc  in  2  BRAM location of the current frame.
REQ-005 SHALL have: i_prev_frame_loc  in  2  BRAM location of the previous frame.
REQ-006 SHALL have: i_match_ready  in  1  matcher accepts a line in the cycle after a read issue.
REQ-007 SHALL have: o_bram_rd_addr  out  9  BRAM read address.
REQ-008 SHALL have: o_bram_rd_en  out  16  one-hot read enable, bit = subimage index.
REQ-009 SHALL have: o_line_valid  out  1  BRAM read data is valid this cycle.
REQ-010 SHALL have: o_line_is_prev  out  1  valid line belongs to the previous frame.
REQ-011 SHALL have: o_subimage_idx  out  4  subimage of the valid line.
REQ-012 SHALL have: o_line_idx  out  6  line (0-63) of the valid line.
REQ-013 SHALL have: o_busy  out  1  schedule in progress.
REQ-014 SHALL have: o_done  out  1  one-cycle pulse at schedule end.
REQ-015 SHALL have: o_overrun  out  1  sticky flag; frame_done arrived while busy.

Function
REQ-016 SHALL implement FSM states IDLE, RD_CURR, RD_PREV, DONE.
REQ-017 IDLE -> RD_CURR on i_frame_done, latching both frame locations; subimage=0, line=0.
REQ-018 A read SHALL issue only in RD_CURR/RD_PREV with i_match_ready=1; otherwise rd_en=0 and counters hold (stall).
REQ-019 Read address SHALL be {1'b0, loc[1:0], line[5:0]}; loc = latched curr loc in RD_CURR, latched prev loc in RD_PREV.
REQ-020 o_bram_rd_en SHALL be 16'b1 << subimage on an issue cycle, else 0.
REQ-021 o_line_valid, o_line_is_prev, o_subimage_idx, o_line_idx SHALL be registered copies of the issue-cycle values, valid exactly 1 cycle after issue (BRAM latency 1).
REQ-022 RD_CURR: after issuing line 63 -> RD_PREV, line=0.
REQ-023 RD_PREV: after issuing line 63 with subimage<15 -> RD_CURR, subimage+1, line=0; with subimage=15 -> DONE.
REQ-024 DONE SHALL assert o_done for 1 cycle, coincident with the last o_line_valid, then return to IDLE.
REQ-025 Unstalled schedule SHALL take exactly 2048 issue cycles; o_done 2049 cycles after i_frame_done.
REQ-026 o_busy SHALL be 1 from the cycle after i_frame_done through DONE inclusive.
REQ-027 i_frame_done while o_busy=1 SHALL be ignored (latched locations unchanged) and SHALL set o_overrun.
REQ-028 i_frame_done in the DONE cycle SHALL count as overrun; the new schedule is not started.
REQ-029 i_curr_frame_loc == i_prev_frame_loc at latch SHALL still be scheduled unchanged (no check).
REQ-030 Counters SHALL wrap only by explicit FSM transition; no modulo overflow paths.

Reset
REQ-031 On i_resetn=0 at a clock edge: state=IDLE; all outputs 0, including o_overrun; counters and latched locations 0.
REQ-032 Reset mid-schedule SHALL abort immediately with no o_done; the next i_frame_done after reset starts a fresh schedule.
REQ-033 o_overrun SHALL be cleared only by reset.

Configuration
REQ-034 Macro GCBP_SCHED_STATS_EN defined: extra output o_sched_cycles[15:0] holds the cycle count (including stalls) from i_frame_done to o_done of the last completed schedule; it saturates at 16'hFFFF and resets to 0.
REQ-035 Macro GCBP_SCHED_STATS_EN undefined: no o_sched_cycles port and no counter logic; all other behaviour is identical.

Structure
REQ-036 Package gcbp_pkg SHALL hold the state enum, C_SUBIMAGE_LINES=64, C_NUM_SUBIMAGES=16, C_BRAM_ADDR_BITS=9, C_FRAME_LOC_BITS=2.
REQ-037 Sub-module gcbp_sched_addr_gen SHALL implement the address formation and one-hot enable decode from loc, subimage and line.

Verification
REQ-038 Reset, locs curr=1/prev=2, frame_done, ready=1 -> first addr 0x040 with rd_en=0x0001; line 64 of the schedule addr 0x080; o_done at +2049 cycles; 2048 valid lines.
REQ-039 Ready low for 10 cycles at subimage 5 line 30 -> no issue during stall; the next valid line is subimage 5 line 30; o_done delayed by 10 cycles.
REQ-040 frame_done at cycle 500 of a schedule -> o_overrun=1; schedule completes with the original locs; o_overrun stays 1 until reset.
REQ-041 Reset asserted at cycle 1000 -> all outputs 0 next cycle, no o_done; a new frame_done runs a full 2048-line schedule.
REQ-042 Last transition -> subimage 15 prev line 63 carries o_line_is_prev=1 and o_line_idx=63, with o_done high in that same cycle.
REQ-043 With STATS_EN and 7 stall cycles -> o_sched_cycles = 2056 after o_done.
